mod_cu: RTL and testbench

- Control unit that sequences the 32-bit repeated-subtraction modulo datapath (mod_dp) to compute a mod b.
- Captures operands on a start/done handshake and holds them stable on the datapath inputs.
- Drives the datapath select (s) and write-enable (we), and watches its less-than status (x).
- Reports completion, divide-by-zero, and the subtraction count to the top-level ALU sequencer.

---
 rtl/mod_pkg.sv | 21 ++
 rtl/mod_iter_cnt.sv | 42 ++++
 rtl/mod_cu.sv | 160 ++++++++++++++++
 tb/tb_mod_cu.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mod_pkg.sv
// Shared definitions for the modulo control unit and its iteration counter.
//   state_e        : control FSM states
//   W_DEF / CW_DEF : default operand and counter widths
//   SEL_A/SEL_ACC  : encodings of the datapath select s
package mod_pkg;

  localparam int unsigned W_DEF  = 32;
  localparam int unsigned CW_DEF = 16;

  localparam logic SEL_A   = 1'b0;
  localparam logic SEL_ACC = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StCheck0,
    StSub0,
    StLoop,
    StDone
  } state_e;

endpackage

// File: rtl/mod_iter_cnt.sv
// Saturating iteration counter for the modulo control unit.
//   CLK    : clock, rising edge
//   RST    : synchronous active-high reset
//   clr    : clear to zero (has priority over inc)
//   inc    : increment by one, holding at all-ones
//   cnt    : current count
//   at_max : cnt equals MAX_ITER
module mod_iter_cnt #(
  parameter int unsigned    CW       = 16,
  parameter logic [CW-1:0]  MAX_ITER = '1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          at_max
);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == MAX_ITER);

endmodule

// File: rtl/mod_cu.sv
// Control unit sequencing the repeated-subtraction modulo datapath (mod_dp) to
// compute a mod b. Operands are captured on an accepted start and held on the
// datapath inputs until the next accepted start.
//
// Build option: define MOD_CU_TIMEOUT_EN to abort the loop with err=1 once
// iter_cnt reaches MAX_ITER while the accumulator is still >= b.
//
// Ports:
//   CLK, RST       : clock (rising edge), synchronous active-high reset
//   start          : request, sampled only while idle
//   a_in, b_in     : dividend / divisor, captured on accepted start
//   x              : datapath status, selected operand < b
//   a_out, b_out   : registered operands to datapath inputs a / b
//   s, we          : datapath select and accumulator write-enable
//   bypass         : result is a_out rather than the accumulator
//   busy, done     : operation in flight / one-cycle completion pulse
//   err            : divide-by-zero (or loop timeout), valid with done
//   iter_cnt       : number of subtractions performed
module mod_cu
  import mod_pkg::*;
#(
  parameter int unsigned   W        = W_DEF,
  parameter int unsigned   CW       = CW_DEF,
  parameter logic [CW-1:0] MAX_ITER = '1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [W-1:0]  a_in,
  input  logic [W-1:0]  b_in,
  input  logic          x,
  output logic [W-1:0]  a_out,
  output logic [W-1:0]  b_out,
  output logic          s,
  output logic          we,
  output logic          bypass,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] iter_cnt
);

`ifdef MOD_CU_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  state_e         state_q;
  logic [W-1:0]   a_q, b_q;
  logic           s_q, bypass_q, busy_q, done_q, err_q;
  logic           cnt_clr, cnt_inc, cnt_at_max;
  logic           timeout;
  logic           we_c;

  assign timeout = TimeoutEn && (state_q == StLoop) && !x && cnt_at_max;

  // we must react to x in the same cycle: in LOOP, x describes the current
  // accumulator, and the subtraction has to land on this very edge.
  always_comb begin
    we_c = 1'b0;
    if (state_q == StSub0) begin
      we_c = 1'b1;
    end else if ((state_q == StLoop) && !x && !timeout) begin
      we_c = 1'b1;
    end
  end

  assign cnt_clr = (state_q == StIdle) && start;
  assign cnt_inc = we_c;

  mod_iter_cnt #(
    .CW       (CW),
    .MAX_ITER (MAX_ITER)
  ) u_iter_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .cnt    (iter_cnt),
    .at_max (cnt_at_max)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= SEL_A;
      bypass_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q      <= a_in;
            b_q      <= b_in;
            err_q    <= 1'b0;
            bypass_q <= 1'b0;
            busy_q   <= 1'b1;
            s_q      <= SEL_A;
            if (b_in == '0) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StCheck0;
            end
          end
        end
        StCheck0: begin
          // x compares a_out against b here
          if (x) begin
            bypass_q <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else begin
            state_q <= StSub0;
          end
        end
        StSub0: begin
          s_q     <= SEL_ACC;
          state_q <= StLoop;
        end
        StLoop: begin
          if (timeout) begin
            err_q   <= 1'b1;
            s_q     <= SEL_A;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (x) begin
            s_q     <= SEL_A;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign a_out  = a_q;
  assign b_out  = b_q;
  assign s      = s_q;
  assign we     = we_c;
  assign bypass = bypass_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mod_cu.sv
// Bench for mod_cu paired with a behavioural model of the subtraction datapath.
module tb_mod_cu;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 16;
`ifdef MOD_CU_TIMEOUT_EN
  localparam bit            TbTimeout = 1'b1;
  localparam logic [CW-1:0] TbMax     = 16'd4;
`else
  localparam bit            TbTimeout = 1'b0;
  localparam logic [CW-1:0] TbMax     = 16'hFFFF;
`endif
  localparam int Bound = 400;

  logic          CLK = 1'b0;
  logic          RST, start;
  logic [W-1:0]  a_in, b_in, a_out, b_out;
  logic          x, s, we, bypass, busy, done, err;
  logic [CW-1:0] iter_cnt;

  // datapath model: selectable operand, comparator, accumulator
  logic [W-1:0] acc = '0;
  logic [W-1:0] sel;
  assign sel = s ? acc : a_out;
  assign x   = (sel < b_out);
  always @(posedge CLK) if (we) acc <= sel - b_out;

  always #5 CLK = ~CLK;

  mod_cu #(
    .W        (W),
    .CW       (CW),
    .MAX_ITER (TbMax)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .x        (x),
    .a_out    (a_out),
    .b_out    (b_out),
    .s        (s),
    .we       (we),
    .bypass   (bypass),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .iter_cnt (iter_cnt)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         chk_res;
    logic         err;
    logic         byp;
    logic [W-1:0] cnt;
    int           lat;
    int           wes;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int unsigned n;
    e.a = a; e.b = b; e.res = '0; e.chk_res = 1'b0; e.err = 1'b0; e.byp = 1'b0;
    e.cnt = '0; e.lat = 0; e.wes = 0;
    if (b == '0) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (a < b) begin
      e.byp = 1'b1; e.res = a; e.chk_res = 1'b1; e.lat = 2;
    end else begin
      n = a / b;
      if (TbTimeout && (n > 32'(TbMax))) begin
        e.err = 1'b1;
        e.cnt = 32'(TbMax);
        e.res = a - 32'(TbMax) * b;
        e.chk_res = 1'b1;
        e.lat = int'(TbMax) + 3;
        e.wes = int'(TbMax);
      end else begin
        e.cnt = (n > 32'hFFFF) ? 32'hFFFF : n;
        e.res = a % b;
        e.chk_res = 1'b1;
        e.lat = int'(n) + 3;
        e.wes = int'(n);
      end
    end
    return e;
  endfunction

  // drive one operation; optionally poke start mid-operation to show it is ignored
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    exp_t e;
    int   cyc, wes;
    bit   seen;
    exp_q.push_back(model(a, b));
    @(negedge CLK);
    start = 1'b1; a_in = a; b_in = b;
    @(posedge CLK);
    #1;
    start = 1'b0; a_in = ~a; b_in = a ^ 32'h5a5a;
    cyc = 0; wes = 0; seen = 1'b0;
    while (!seen && cyc < Bound) begin
      @(negedge CLK);
      cyc++;
      if (we) wes++;
      if (cyc == 1) check_eq("busy_c1", W'(busy), 1);
      if (done) seen = 1'b1;
      if (poke && cyc == 2) begin start = 1'b1; a_in = 32'd1; b_in = 32'd1; end
      if (poke && cyc == 3) start = 1'b0;
    end
    e = exp_q.pop_front();
    check_eq("done_seen", W'(seen), 1);
    check_eq("latency", W'(cyc), W'(e.lat));
    check_eq("err", W'(err), W'(e.err));
    check_eq("bypass", W'(bypass), W'(e.byp));
    check_eq("iter_cnt", W'(iter_cnt), e.cnt);
    check_eq("we_pulses", W'(wes), W'(e.wes));
    check_eq("a_out", a_out, e.a);
    check_eq("b_out", b_out, e.b);
    check_eq("busy_done", W'(busy), 1);
    if (e.chk_res) check_eq("result", bypass ? a_out : acc, e.res);
    @(negedge CLK);
    check_eq("done_pulse", W'(done), 0);
    check_eq("busy_idle", W'(busy), 0);
    check_eq("cnt_held", W'(iter_cnt), e.cnt);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_a"}, a_out, 0);
    check_eq({tag, "_b"}, b_out, 0);
    check_eq({tag, "_ctl"}, W'({s, we, bypass, busy, done, err}), 0);
    check_eq({tag, "_cnt"}, W'(iter_cnt), 0);
  endtask

  initial begin
    int cyc, dones;
    RST = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_zero("reset");
    RST = 1'b0;

    run_op(32'd38, 32'd7, 1'b1);
    run_op(32'd5, 32'd9, 1'b0);
    run_op(32'd7, 32'd7, 1'b0);
    run_op(32'd123, 32'd0, 1'b0);

    // reset mid-operation aborts with no done
    @(negedge CLK);
    start = 1'b1; a_in = 32'd38; b_in = 32'd7;
    @(posedge CLK);
    #1 start = 1'b0;
    dones = 0;
    for (cyc = 1; cyc <= 3; cyc++) begin
      @(negedge CLK);
      if (done) dones++;
    end
    RST = 1'b1;
    @(negedge CLK);
    check_zero("abort");
    RST = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (done) dones++;
    end
    check_eq("abort_no_done", W'(dones), 0);

    run_op(32'd20, 32'd6, 1'b0);
    run_op(32'd100, 32'd3, 1'b0);

    repeat (8) run_op(W'($urandom_range(0, 300)), W'($urandom_range(0, 40)), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
